// File: rtl/des_round_sequencer.sv
// Iterative DES controller: drives one external combinational Feistel round per clock
// for ROUNDS rounds, then applies the final half swap and pulses done.
module des_round_sequencer #(
    parameter int unsigned ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [31:0] in_left,
    input  logic [31:0] in_right,
    output logic [3:0]  round_idx,
    input  logic [47:0] round_key,
    output logic [31:0] rnd_in_left,
    output logic [31:0] rnd_in_right,
    output logic [47:0] rnd_key,
    input  logic [31:0] rnd_out_left,
    input  logic [31:0] rnd_out_right,
    output logic [31:0] out_left,
    output logic [31:0] out_right,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] l_half;
    logic [31:0] r_half;
    logic [3:0]  cnt;
    logic        mode;
    logic        last_round;

    assign last_round   = (cnt == LAST_CNT);
    assign round_idx    = mode ? (LAST_CNT - cnt) : cnt;
    assign rnd_in_left  = l_half;
    assign rnd_in_right = r_half;
    assign rnd_key      = round_key;

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_round) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            l_half    <= '0;
            r_half    <= '0;
            cnt       <= '0;
            mode      <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        l_half <= in_left;
                        r_half <= in_right;
                        cnt    <= '0;
                        mode   <= decrypt;
                    end
                end
                RUN: begin
                    l_half <= rnd_out_left;
                    r_half <= rnd_out_right;
                    if (last_round) begin
                        // Final DES swap: the last round's halves leave crossed over.
                        cnt       <= '0;
                        done      <= 1'b1;
                        out_left  <= rnd_out_right;
                        out_right <= rnd_out_left;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
